// File: rtl/fusion_frame_sched.sv
// fusion_frame_sched: frame-level fetch/run/drain scheduler for temporal fusion.
// Optional idle-beat watchdog enabled by defining FUSION_SCHED_TIMEOUT_EN.
module fusion_frame_sched #(
  parameter int IM_LEN            = 520,
  parameter int IM_WID            = 520,
  parameter int NO_IMAGES         = 16,
  parameter int LOG2_NO_OF_IMAGES = 4,
  parameter int DATA_WIDTH        = 128,
  parameter int PIPELINE_LATENCY  = 20,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                         s_axis_clk,
  input  logic                         s_axis_aresetn,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         beat_fire,
  input  logic                         beat_last,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic [31:0]                  req_frame,
  output logic                         mode,
  output logic [LOG2_NO_OF_IMAGES-1:0] frame_slot,
  output logic                         wb_en,
  output logic                         in_enable,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         err_len,
  output logic                         err_timeout
);

  localparam int BEATS = IM_LEN * IM_WID * 8 / DATA_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = $clog2(PIPELINE_LATENCY + 1);
  localparam int SW    = LOG2_NO_OF_IMAGES;

  localparam logic [BW-1:0] BEAT_MAX   = BW'(BEATS - 1);
  localparam logic [DW-1:0] DRAIN_DONE = DW'(PIPELINE_LATENCY - 1);
  localparam logic [DW-1:0] DRAIN_EXIT = DW'(PIPELINE_LATENCY);
  localparam logic [SW-1:0] SLOT_MAX   = SW'(NO_IMAGES - 1);

  // Reject parameter sets the counters cannot represent.
  if ((BEATS * DATA_WIDTH != IM_LEN * IM_WID * 8) ||
      (PIPELINE_LATENCY < 1) || (TIMEOUT_CYCLES < 2) ||
      ((1 << LOG2_NO_OF_IMAGES) != NO_IMAGES)) begin : g_bad_param
    $error("fusion_frame_sched: unsupported parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic            r_req_valid;
  logic            r_in_enable;
  logic            r_frame_done;
  logic [31:0]     r_req_frame;
  logic [SW-1:0]   r_slot;
  logic            r_mode;
  logic            r_err_len;
  logic [BW-1:0]   r_beat_cnt;
  logic [DW-1:0]   r_drain_cnt;

  logic w_go;
  logic w_hs;
  logic w_fire;
  logic w_fire_last;
  logic w_retire;
  logic w_exit;
  logic w_to;

  // State register.
  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    w_state_nx  = r_state;
    w_go        = 1'b0;
    w_hs        = 1'b0;
    w_fire      = 1'b0;
    w_fire_last = 1'b0;
    w_retire    = 1'b0;
    w_exit      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_go       = 1'b1;
          w_state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          w_hs       = 1'b1;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (beat_fire && r_in_enable) begin
          w_fire = 1'b1;
          if (r_beat_cnt == BEAT_MAX) begin
            w_fire_last = 1'b1;
            w_state_nx  = S_DRAIN;
          end
        end else if (w_to) begin
          w_state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == DRAIN_DONE) begin
          w_retire = 1'b1;
        end
        if (r_drain_cnt == DRAIN_EXIT) begin
          w_exit     = 1'b1;
          w_state_nx = stop ? S_IDLE : S_REQ;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Handshake/enable flags follow the next state so they are registered.
  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_req_valid  <= 1'b0;
      r_in_enable  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_req_valid  <= (w_state_nx == S_REQ);
      r_in_enable  <= (w_state_nx == S_RUN);
      r_frame_done <= w_retire;
    end
  end

  // Beat and drain counters; tlast is only checked, never used to end a frame.
  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_err_len   <= 1'b0;
    end else begin
      if (w_go) begin
        r_err_len <= 1'b0;
      end
      if (w_hs) begin
        r_beat_cnt <= '0;
      end else if (w_fire) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (beat_last != w_fire_last) begin
          r_err_len <= 1'b1;
        end
      end
      if (w_fire_last) begin
        r_drain_cnt <= '0;
      end else if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end
    end
  end

  // Frame number, window slot and build/fuse mode advance at retirement.
  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_req_frame <= '0;
      r_slot      <= '0;
      r_mode      <= 1'b0;
    end else if (w_go) begin
      r_req_frame <= '0;
      r_slot      <= '0;
      r_mode      <= 1'b0;
    end else if (w_retire) begin
      r_req_frame <= r_req_frame + 32'd1;
      if (r_slot == SLOT_MAX) begin
        r_slot <= '0;
        r_mode <= 1'b1;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

`ifdef FUSION_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err_timeout;

  assign w_to = (r_state == S_RUN) && (r_to_cnt == TO_MAX);

  // Idle-beat watchdog: restarts on every accepted beat while running.
  always_ff @(posedge s_axis_clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_go) begin
        r_err_timeout <= 1'b0;
      end
      if ((r_state == S_RUN) && !w_fire) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (w_to) begin
          r_err_timeout <= 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_to        = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign req_valid  = r_req_valid;
  assign in_enable  = r_in_enable;
  assign frame_done = r_frame_done;
  assign req_frame  = r_req_frame;
  assign frame_slot = r_slot;
  assign mode       = r_mode;
  assign err_len    = r_err_len;
  assign wb_en      = r_mode && (r_slot == SLOT_MAX);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fusion_frame_sched.sv
// tb_fusion_frame_sched: scoreboard bench for fusion_frame_sched.
// Request and retirement expectations are queued and popped by monitors.
module tb_fusion_frame_sched;

  localparam int PL    = 3;
  localparam int BEATS = 4;
  localparam int NI    = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        start     = 1'b0;
  logic        stop      = 1'b0;
  logic        beat_fire = 1'b0;
  logic        beat_last = 1'b0;
  logic        req_ready = 1'b1;
  logic        req_valid;
  logic [31:0] req_frame;
  logic        mode;
  logic [1:0]  frame_slot;
  logic        wb_en;
  logic        in_enable;
  logic        frame_done;
  logic        busy;
  logic        err_len;
  logic        err_timeout;

  fusion_frame_sched #(
    .IM_LEN(8), .IM_WID(8), .NO_IMAGES(NI), .LOG2_NO_OF_IMAGES(2),
    .DATA_WIDTH(128), .PIPELINE_LATENCY(PL), .TIMEOUT_CYCLES(8)
  ) dut (
    .s_axis_clk(clk), .s_axis_aresetn(rst_n),
    .start(start), .stop(stop),
    .beat_fire(beat_fire), .beat_last(beat_last),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_frame(req_frame), .mode(mode), .frame_slot(frame_slot),
    .wb_en(wb_en), .in_enable(in_enable), .frame_done(frame_done),
    .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int frame;
    int slot;
    bit md;
  } req_t;

  req_t q_req[$];
  int   q_done[$];
  req_t m_e;
  int   m_d;
  bit   m_wb;

  // Monitor: checks every request handshake and every frame_done pulse.
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      n_checks++;
      if (q_req.size() == 0) begin
        n_err++;
        $display("FAIL req_unexpected: req_frame=%0d, expected no request",
                 req_frame);
      end else begin
        m_e  = q_req.pop_front();
        m_wb = m_e.md && (m_e.slot == NI - 1);
        if (req_frame !== 32'(m_e.frame) || frame_slot !== m_e.slot[1:0] ||
            mode !== m_e.md || wb_en !== m_wb) begin
          n_err++;
          $display("FAIL req_fields: frame/slot/mode/wb=%0d/%0d/%0b/%0b expected %0d/%0d/%0b/%0b",
                   req_frame, frame_slot, mode, wb_en,
                   m_e.frame, m_e.slot, m_e.md, m_wb);
        end
      end
    end
    if (rst_n && frame_done) begin
      n_checks++;
      if (q_done.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: frame_done at cycle %0d, expected none", cyc);
      end else begin
        m_d = q_done.pop_front();
        if (cyc !== m_d) begin
          n_err++;
          $display("FAIL done_cycle: frame_done at cycle %0d, expected %0d", cyc, m_d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) begin
      q_req.push_back('{frame: i, slot: i % NI, md: (i >= NI)});
    end
  endtask

  task automatic wait_en;
    int n = 0;
    while (!in_enable && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (in_enable !== 1'b1) begin
      n_err++;
      $display("FAIL wait_in_enable: in_enable=%b after %0d cycles, expected 1", in_enable, n);
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic do_frame(input int tlast_at, input bit set_stop);
    wait_en();
    if (set_stop) stop = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      beat_fire = 1'b1;
      beat_last = (b == tlast_at);
      if (b == BEATS - 1) q_done.push_back(cyc + PL + 1);
      tick();
    end
    beat_fire = 1'b0;
    beat_last = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #20;
    n_checks++;
    if ({req_valid, in_enable, frame_done, busy, wb_en, mode, err_len, err_timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_flags: flags=%b expected 00000000",
               {req_valid, in_enable, frame_done, busy, wb_en, mode, err_len, err_timeout});
    end
    n_checks++;
    if (req_frame !== 32'd0 || frame_slot !== 2'd0) begin
      n_err++;
      $display("FAIL reset_counters: req_frame=%0d slot=%0d expected 0/0", req_frame, frame_slot);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_main;
    stop = 1'b0;
    push_run(8);
    pulse_start();
    n_checks++;
    if (req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL start_to_req: req_valid=%b expected 1", req_valid);
    end
    tick();
    n_checks++;
    if (in_enable !== 1'b1) begin
      n_err++;
      $display("FAIL hs_to_enable: in_enable=%b expected 1", in_enable);
    end
    for (int f = 0; f < 8; f++) do_frame(3, f == 7);
    wait_idle();
    stop = 1'b0;
    n_checks++;
    if (err_len !== 1'b0 || mode !== 1'b1) begin
      n_err++;
      $display("FAIL main_end: err_len=%b mode=%b expected 0/1", err_len, mode);
    end
  endtask

  task automatic test_backpressure;
    req_ready = 1'b0;
    push_run(1);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (req_valid !== 1'b1 || req_frame !== 32'd0 || in_enable !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure: valid=%b frame=%0d en=%b expected 1/0/0",
                 req_valid, req_frame, in_enable);
      end
      tick();
    end
    req_ready = 1'b1;
    do_frame(3, 1'b1);
    wait_idle();
    stop = 1'b0;
  endtask

  task automatic test_err_len;
    push_run(1);
    pulse_start();
    do_frame(1, 1'b1);
    wait_idle();
    n_checks++;
    if (err_len !== 1'b1) begin
      n_err++;
      $display("FAIL err_len_set: err_len=%b expected 1", err_len);
    end
    push_run(1);
    stop = 1'b1;
    pulse_start();
    n_checks++;
    if (err_len !== 1'b0) begin
      n_err++;
      $display("FAIL err_len_clear: err_len=%b expected 0", err_len);
    end
    do_frame(3, 1'b1);
    wait_idle();
    stop = 1'b0;
    n_checks++;
    if (err_len !== 1'b0) begin
      n_err++;
      $display("FAIL err_len_clean: err_len=%b expected 0", err_len);
    end
  endtask

  task automatic test_stop;
    int seen = 0;
    stop = 1'b0;
    push_run(3);
    pulse_start();
    do_frame(3, 1'b0);
    do_frame(3, 1'b0);
    do_frame(3, 1'b1);
    wait_idle();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid) seen++;
      tick();
    end
    n_checks++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_idle: req_valid cycles=%0d busy=%b expected 0/0", seen, busy);
    end
  endtask

  task automatic test_reset_mid;
    push_run(1);
    pulse_start();
    wait_en();
    for (int b = 0; b < 2; b++) begin
      beat_fire = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_valid, in_enable, frame_done, busy, wb_en, mode, err_len, err_timeout} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_flags: flags=%b expected 00000000",
               {req_valid, in_enable, frame_done, busy, wb_en, mode, err_len, err_timeout});
    end
    n_checks++;
    if (req_frame !== 32'd0 || frame_slot !== 2'd0) begin
      n_err++;
      $display("FAIL reset_mid_counters: req_frame=%0d slot=%0d expected 0/0", req_frame, frame_slot);
    end
    beat_fire = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push_run(1);
    stop = 1'b1;
    pulse_start();
    do_frame(3, 1'b1);
    wait_idle();
    stop = 1'b0;
  endtask

  task automatic test_timeout;
    int n = 0;
    push_run(1);
    stop = 1'b1;
    pulse_start();
    wait_en();
`ifdef FUSION_SCHED_TIMEOUT_EN
    while (busy && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== 8 || err_timeout !== 1'b1 || in_enable !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_fire: cycles=%0d err_timeout=%b en=%b expected 8/1/0",
               n, err_timeout, in_enable);
    end
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      n++;
    end
    n_checks++;
    if (busy !== 1'b1 || in_enable !== 1'b1 || err_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_absent: busy=%b en=%b err_timeout=%b after %0d cycles expected 1/1/0",
               busy, in_enable, err_timeout, n);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
`endif
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_main();
    test_backpressure();
    test_err_len();
    test_stop();
    test_reset_mid();
    test_timeout();
    repeat (5) tick();
    n_checks++;
    if (q_req.size() !== 0) begin
      n_err++;
      $display("FAIL req_queue_left: %0d requests outstanding, expected 0", q_req.size());
    end
    n_checks++;
    if (q_done.size() !== 0) begin
      n_err++;
      $display("FAIL done_queue_left: %0d retirements outstanding, expected 0", q_done.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
